// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcode and FSM state encodings.
package alu_pkg;

  localparam int unsigned OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLL = 3'd5,
    ALU_SRA = 3'd6,
    ALU_MUL = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StHold
  } state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier returning the low N bits of a*b.
// Bit 0 is folded in at start, so done rises N-1 cycles after the start edge.
module alu_mul_iter #(
  parameter int unsigned N = 16
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         done,
  output logic [N-1:0] p
);

  localparam int unsigned CntW = $clog2(N);

  logic            run_q;
  logic [CntW-1:0] cnt_q;
  logic [N-1:0]    acc_q;
  logic [N-1:0]    mcand_q;
  logic [N-1:0]    mplier_q;

  // Low N bits of a two's-complement product equal those of the unsigned product.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      run_q    <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else if (start) begin
      run_q    <= 1'b1;
      cnt_q    <= CntW'(N - 1);
      acc_q    <= b[0] ? a : '0;
      mcand_q  <= a << 1;
      mplier_q <= b >> 1;
    end else if (run_q) begin
      if (cnt_q == '0) begin
        run_q <= 1'b0;
      end else begin
        cnt_q    <= cnt_q - CntW'(1);
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        if (mplier_q[0]) begin
          acc_q <= acc_q + mcand_q;
        end
      end
    end
  end

  always_comb begin
    done = run_q && (cnt_q == '0);
    p    = acc_q;
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshakes: single-cycle ops plus an
// iterative multiply, result and flags held until the consumer takes them.
module alu_seq #(
  parameter int unsigned N    = 16,
  parameter int unsigned OP_W = 3
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N-1:0]    in1,
  input  logic [N-1:0]    in2,
  input  logic [OP_W-1:0] alu_op,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N-1:0]    alu_out,
  output logic            z,
  output logic            v,
  output logic            busy
);

  import alu_pkg::*;

  localparam int unsigned ShW = $clog2(N);

  state_e       state_q;
  logic [N-1:0] alu_out_q;
  logic         z_q;
  logic         v_q;

  alu_op_e      op;
  logic         accept;
  logic [N-1:0] sum;
  logic [N-1:0] diff;
  logic [N-1:0] res_c;
  logic         v_c;
  logic         mul_start;
  logic         mul_done;
  logic [N-1:0] mul_p;

  always_comb begin
    in_ready  = (state_q == StIdle) || ((state_q == StHold) && out_ready);
    out_valid = (state_q == StHold);
    busy      = (state_q == StMul);
    alu_out   = alu_out_q;
    z         = z_q;
    v         = v_q;
    op        = alu_op_e'(alu_op);
    accept    = in_valid && in_ready;
    mul_start = accept && (op == ALU_MUL);
  end

  always_comb begin
    sum   = in1 + in2;
    diff  = in1 - in2;
    res_c = '0;
    v_c   = 1'b0;
    case (op)
      ALU_ADD: begin
        res_c = sum;
        v_c   = (in1[N-1] == in2[N-1]) && (sum[N-1] != in1[N-1]);
      end
      ALU_SUB: begin
        res_c = diff;
        v_c   = (in1[N-1] != in2[N-1]) && (diff[N-1] != in1[N-1]);
      end
      ALU_AND: res_c = in1 & in2;
      ALU_OR:  res_c = in1 | in2;
      ALU_XOR: res_c = in1 ^ in2;
      ALU_SLL: res_c = in1 << in2[ShW-1:0];
      ALU_SRA: res_c = $signed(in1) >>> in2[ShW-1:0];
      default: res_c = '0;
    endcase
  end

  alu_mul_iter #(
    .N(N)
  ) u_mul (
    .clk  (clk),
    .rstn (rstn),
    .start(mul_start),
    .a    (in1),
    .b    (in2),
    .done (mul_done),
    .p    (mul_p)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= StIdle;
      alu_out_q <= '0;
      z_q       <= 1'b1;
      v_q       <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StHold: begin
          if (accept) begin
            if (op == ALU_MUL) begin
              state_q <= StMul;
            end else begin
              state_q   <= StHold;
              alu_out_q <= res_c;
              z_q       <= (res_c == '0);
              v_q       <= v_c;
            end
          end else if ((state_q == StHold) && out_ready) begin
            state_q <= StIdle;
          end
        end
        StMul: begin
          if (mul_done) begin
            state_q   <= StHold;
            alu_out_q <= mul_p;
            z_q       <= (mul_p == '0);
            v_q       <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at N=16: directed handshake/latency cases plus random ops.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int unsigned N = 16;

  logic         clk = 1'b0;
  logic         rstn;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in1;
  logic [N-1:0] in2;
  logic [2:0]   alu_op;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] alu_out;
  logic         z;
  logic         v;
  logic         busy;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [17:0] sb_q[$];
  bit          rand_ready = 1'b0;
  bit          rnd_ready  = 1'b1;
  bit          fix_ready  = 1'b1;

  assign out_ready = rand_ready ? rnd_ready : fix_ready;

  always #5 clk = ~clk;

  alu_seq #(
    .N   (N),
    .OP_W(3)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in1      (in1),
    .in2      (in2),
    .alu_op   (alu_op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .alu_out  (alu_out),
    .z        (z),
    .v        (v),
    .busy     (busy)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference result packed as {value, z, v}.
  function automatic logic [17:0] model(input logic [2:0] op, input logic [15:0] a,
                                        input logic [15:0] b);
    int          sa;
    int          sb;
    int          t;
    longint      pr;
    logic [15:0] r;
    logic        ov;
    sa = $signed(a);
    sb = $signed(b);
    ov = 1'b0;
    r  = '0;
    case (op)
      3'd0: begin t = sa + sb; ov = (t > 32767) || (t < -32768); r = t[15:0]; end
      3'd1: begin t = sa - sb; ov = (t > 32767) || (t < -32768); r = t[15:0]; end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = a << b[3:0];
      3'd6: begin t = sa >>> b[3:0]; r = t[15:0]; end
      default: begin pr = longint'(sa) * longint'(sb); r = pr[15:0]; end
    endcase
    return {r, (r == 16'h0), ov};
  endfunction

  always @(posedge clk) begin
    #1;
    rnd_ready = ($urandom_range(0, 3) != 0);
  end

  always @(negedge clk) begin
    logic [17:0] e;
    if (rstn === 1'b1 && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check_eq("sb_depth", sb_q.size(), 1);
      end else begin
        e = sb_q.pop_front();
        check_eq("result", {alu_out, z, v}, e);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accept edge.
  task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       output int waits);
    in_valid = 1'b1;
    alu_op   = op;
    in1      = a;
    in2      = b;
    waits    = 0;
    @(negedge clk);
    while (!in_ready && waits < 100) begin
      waits++;
      @(negedge clk);
    end
    if (!in_ready) check_eq("issue_timeout", in_ready, 1);
    else sb_q.push_back(model(op, a, b));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w;
    int n_busy;
    int n_ov;
    logic [2:0]  rop;
    logic [15:0] ra;
    logic [15:0] rb;

    rstn     = 1'b0;
    in_valid = 1'b1;
    alu_op   = ALU_ADD;
    in1      = 16'd5;
    in2      = 16'd10;
    #12;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_alu_out", alu_out, 0);
    check_eq("rst_z", z, 1);
    check_eq("rst_v", v, 0);

    // First accept on the first rising edge after release.
    @(negedge clk);
    rstn = 1'b1;
    sb_q.push_back(model(ALU_ADD, 16'd5, 16'd10));
    #1;
    check_eq("rel_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_eq("add_latency", out_valid, 1);

    issue(ALU_SUB, 16'd30, 16'd30, w);
    issue(ALU_ADD, 16'h7fff, 16'd1, w);
    check_eq("b2b_wait", w, 0);

    issue(ALU_MUL, 16'hfffd, 16'd7, w);
    n_busy = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_valid) break;
      if (busy && !in_ready) n_busy++;
      in1 = 16'($urandom);
      in2 = 16'($urandom);
    end
    check_eq("mul_busy_cycles", n_busy, 16);
    check_eq("mul_out_valid", out_valid, 1);
    @(posedge clk);
    #1;
    issue(ALU_SRA, 16'h8000, 16'd4, w);

    // Backpressure: result held, new requests ignored while stalled.
    @(posedge clk);
    #1;
    fix_ready = 1'b0;
    issue(ALU_ADD, 16'd5, 16'd10, w);
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      alu_op   = ALU_XOR;
      in1      = 16'h1234;
      in2      = 16'h00ff;
      @(negedge clk);
      check_eq("bp_out_valid", out_valid, 1);
      check_eq("bp_alu_out", alu_out, 15);
      check_eq("bp_in_ready", in_ready, 0);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    fix_ready = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("bp_idle_valid", out_valid, 0);
    check_eq("bp_idle_ready", in_ready, 1);
    @(posedge clk);
    #1;

    rand_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = ($urandom_range(0, 3) == 0) ? 16'h7fff : 16'($urandom);
      rb  = ($urandom_range(0, 3) == 0) ? 16'h8000 : 16'($urandom);
      issue(rop, ra, rb, w);
    end
    rand_ready = 1'b0;
    @(posedge clk);
    #2;
    fix_ready = 1'b1;
    for (int k = 0; k < 60 && sb_q.size() != 0; k++) @(posedge clk);
    #2;
    check_eq("drain", sb_q.size(), 0);

    // Reset in the middle of a multiply.
    @(posedge clk);
    #1;
    issue(ALU_MUL, 16'd100, 16'd200, w);
    repeat (7) @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    sb_q.delete();
    check_eq("mrst_out_valid", out_valid, 0);
    check_eq("mrst_busy", busy, 0);
    check_eq("mrst_alu_out", alu_out, 0);
    check_eq("mrst_z", z, 1);
    check_eq("mrst_v", v, 0);
    @(negedge clk);
    rstn = 1'b1;
    n_ov = 0;
    repeat (25) begin
      @(negedge clk);
      if (out_valid) n_ov++;
    end
    check_eq("mrst_no_valid", n_ov, 0);
    check_eq("mrst_in_ready", in_ready, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter N, default 16: operand and result width in bits; legal range 4..64.
REQ-002 Parameter OP_W, default 3: opcode width; fixed at 3 for this generation.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rstn  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  operands and opcode are presented.
REQ-006 in_ready  output  1  block can accept a new operation this cycle.
REQ-007 in1  input  N  signed operand A.
REQ-008 in2  input  N  signed operand B; for shifts only in2[$clog2(N)-1:0] is used.
REQ-009 alu_op  input  OP_W  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRA, 7 MUL.
REQ-010 out_valid  output  1  alu_out and the flags hold a result.
REQ-011 out_ready  input  1  consumer takes the result this cycle.
REQ-012 alu_out  output  N  registered result.
REQ-013 z  output  1  zero flag: alu_out == 0.
REQ-014 v  output  1  signed overflow flag; meaningful for ADD/SUB only, 0 for all other ops.
REQ-015 busy  output  1  high while an iterative MUL is in progress.

Function
REQ-016 Accept = in_valid && in_ready; operands and opcode are captured only on accept.
REQ-017 FSM states: IDLE, MUL, HOLD.
REQ-018 IDLE: in_ready=1, out_valid=0; accept of ops 0-6 goes to HOLD; accept of op 7 goes to MUL.
REQ-019 Ops 0-6: result registered on the accept edge; out_valid=1 on the next cycle, so latency is 1 cycle.
REQ-020 ADD/SUB: result wraps modulo 2^N; v=1 when operand signs make the true result unrepresentable in N bits.
REQ-021 SLL: logical left shift. SRA: arithmetic right shift. Shift amount 0 passes in1 unchanged.
REQ-022 MUL: signed in1*in2, low N bits returned; computed by iterative shift-add, one bit per cycle over N cycles.
REQ-023 MUL latency: out_valid asserts exactly N+1 cycles after the accept edge.
REQ-024 MUL timing: busy=1 and in_ready=0 throughout MUL state.
REQ-025 HOLD: out_valid=1; alu_out, z and v are stable until the cycle where out_ready=1.
REQ-026 HOLD with out_ready=1 and no new accept: go to IDLE.
REQ-027 HOLD: in_ready = out_ready, so back-to-back issue is allowed.
REQ-028 HOLD with out_ready=1 and in_valid=1: the new op is accepted in the same cycle; the next state is HOLD for ops 0-6 or MUL for op 7, with no bubble.
REQ-029 in_valid is ignored when in_ready=0; operand changes during MUL or stalled HOLD do not affect the result.
REQ-030 z and v are registered together with alu_out and update only when a new result is loaded.

Reset
REQ-031 rstn=0 forces state IDLE and alu_out=0, z=1, v=0, out_valid=0, busy=0, with in_ready=1 once rstn=1.
REQ-032 Reset asserted mid-MUL or in HOLD abandons the operation; no out_valid pulse follows release.
REQ-033 The first accept is possible on the first rising edge with rstn=1.

Structure
REQ-034 Shared package alu_pkg holds the opcode enum (ALU_ADD..ALU_MUL), the FSM state enum and OP_W.
REQ-035 The iterative multiplier is sub-module alu_mul_iter, with ports clk, rstn, start, a, b, done, p[N-1:0].
REQ-036 Ops 0-6 are combinational logic inside alu_seq, feeding the result register.

Verification (N=16)
REQ-037 ADD with in1=5, in2=10, out_ready=1 -> the next cycle gives out_valid=1, alu_out=15, z=0, v=0.
REQ-038 SUB 30-30 then ADD 0x7FFF+1 issued back-to-back -> alu_out=0 with z=1, then alu_out=0x8000 with v=1 one cycle later.
REQ-039 MUL with in1=-3, in2=7 -> busy=1 for 16 cycles, then out_valid=1 at cycle 17 with alu_out=0xFFEB; SRA 0x8000 by 4 -> 0xF800.
REQ-040 Backpressure: result 15 with out_ready=0 for 3 cycles -> alu_out held, in_ready=0; out_ready=1 -> IDLE the next cycle.
REQ-041 rstn pulsed low at MUL cycle 8 -> outputs take reset values immediately; after release, no out_valid and in_ready=1.
